// File: rtl/cache_line_arbiter_if.sv
// Line-sized request/response bundle between the two L1 miss ports, the
// arbiter and the shared downstream memory port.
interface cache_line_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_line_arbiter.sv
// Shares one line-sized downstream port between the icache and dcache miss
// ports: one latched request per grant, response routed back to the grantee.
module cache_line_arbiter #(
  parameter int LINE_W      = 256,
  parameter int ADDR_W      = 32,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_line_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]      i_grant_cnt,
  output logic [CNT_W-1:0]      d_grant_cnt,
  output logic [CNT_W-1:0]      conflict_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0]  c_cnt_q, c_cnt_d;

  logic i_req, d_req, pick_d, serving, resp_i, resp_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Arbitration, request latching, response routing and next state.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    c_cnt_d   = c_cnt_q;
    resp_i    = 1'b0;
    resp_d    = 1'b0;
    i_req     = bus.i_read;
    d_req     = bus.d_read | bus.d_write;

    if (ROUND_ROBIN) begin
      pick_d = d_req & (~i_req | ~last_d_q);
    end else begin
      pick_d = d_req;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          c_cnt_d = sat_inc(c_cnt_q);
        end else begin
          c_cnt_d = c_cnt_q;
        end
        // Simultaneous read+write from the dcache is a writeback.
        if (pick_d) begin
          state_d  = ST_SERVE_D;
          last_d_d = 1'b1;
          wr_d     = bus.d_write;
          addr_d   = bus.d_address;
          wdata_d  = bus.d_wdata;
          d_cnt_d  = sat_inc(d_cnt_q);
        end else if (i_req) begin
          state_d  = ST_SERVE_I;
          last_d_d = 1'b0;
          wr_d     = 1'b0;
          addr_d   = bus.i_address;
          wdata_d  = {LINE_W{1'b0}};
          i_cnt_d  = sat_inc(i_cnt_q);
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SERVE_I: begin
        if (bus.mem_resp && !rst) begin
          resp_i  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SERVE_I;
        end
      end
      ST_SERVE_D: begin
        if (bus.mem_resp && !rst) begin
          resp_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SERVE_D;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    i_rdata_d = resp_i ? bus.mem_rdata : i_rdata_q;
    d_rdata_d = resp_d ? bus.mem_rdata : d_rdata_q;
  end

  // State, latched request, returned lines and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_d_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {LINE_W{1'b0}};
      i_rdata_q <= {LINE_W{1'b0}};
      d_rdata_q <= {LINE_W{1'b0}};
      i_cnt_q   <= {CNT_W{1'b0}};
      d_cnt_q   <= {CNT_W{1'b0}};
      c_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      c_cnt_q   <= c_cnt_d;
    end
  end

  assign serving         = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
  assign bus.mem_read    = serving & ~wr_q;
  assign bus.mem_write   = serving & wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_resp      = resp_i;
  assign bus.d_resp      = resp_d;
  assign bus.i_rdata     = i_rdata_d;
  assign bus.d_rdata     = d_rdata_d;
  assign i_grant_cnt     = i_cnt_q;
  assign d_grant_cnt     = d_cnt_q;
  assign conflict_cnt    = c_cnt_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scoreboard bench: a cycle-numbered reference model predicts grants and
// responses; an independent monitor checks every downstream and upstream event.
module tb_cache_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_fp;
  logic [31:0] i_cnt, d_cnt, c_cnt;
  logic [1:0]  fi_cnt, fd_cnt, fc_cnt;

  cache_line_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cache_line_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus_fp ();

  cache_line_arbiter #(.LINE_W(LW), .ADDR_W(AW), .ROUND_ROBIN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .i_grant_cnt(i_cnt), .d_grant_cnt(d_cnt), .conflict_cnt(c_cnt)
  );

  cache_line_arbiter #(.LINE_W(LW), .ADDR_W(AW), .ROUND_ROBIN(1'b0), .CNT_W(2)) dut_fp (
    .clk(clk), .rst(rst_fp), .bus(bus_fp),
    .i_grant_cnt(fi_cnt), .d_grant_cnt(fd_cnt), .conflict_cnt(fc_cnt)
  );

  typedef struct { bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } mem_t;
  typedef struct { bit is_d; bit wr; logic [LW-1:0] rdata; } resp_t;

  mem_t  exp_mem_q[$];
  resp_t exp_resp_q[$];
  int    compared = 0;
  int    mismatched = 0;
  bit    fp_done = 1'b0;

  // Reference model state, expressed in absolute cycle numbers.
  int cyc, free_cycle, grant_cycle, resp_cycle, i_done, d_done;
  int m_i, m_d, m_c, fixed_lat;
  bit last_grant_d, cur_d, cur_wr, i_pend, d_pend, d_rd_op, d_wr_op;
  bit rand_en, use_fixed;
  logic [LW-1:0] fixed_rdata;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_init();
    cyc = 0; free_cycle = 0; grant_cycle = -100; resp_cycle = -100;
    i_done = -100; d_done = -100; m_i = 0; m_d = 0; m_c = 0;
    last_grant_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    exp_mem_q.delete(); exp_resp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_pend = 1'b0; d_pend = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_init();
  endtask

  // One cycle of stimulus: memory side, requesters, then the model's arbitration.
  task automatic run_cycle();
    logic [LW-1:0] rd;
    bit serving, ir, dr, pick_d;
    int lat;
    @(posedge clk); #1;
    cyc++;
    serving = (cyc > grant_cycle) && (cyc <= resp_cycle);
    if (cyc == resp_cycle) begin
      rd = use_fixed ? fixed_rdata : rnd_line();
      bus.mem_resp = 1'b1; bus.mem_rdata = rd;
      exp_resp_q.push_back('{cur_d, cur_wr, rd});
      if (cur_d) begin d_pend = 1'b0; d_done = cyc; end
      else begin i_pend = 1'b0; i_done = cyc; end
    end else if (!serving && rand_en && $urandom_range(0, 7) == 0) begin
      bus.mem_resp = 1'b1; bus.mem_rdata = rnd_line();
    end else begin
      bus.mem_resp = 1'b0; bus.mem_rdata = rnd_line();
    end
    if (rand_en) begin
      if (!i_pend && cyc > i_done && $urandom_range(0, 3) == 0) begin
        i_pend = 1'b1; bus.i_address = $urandom;
      end
      if (!d_pend && cyc > d_done && $urandom_range(0, 3) == 0) begin
        lat = $urandom_range(0, 2);
        d_pend = 1'b1; d_rd_op = (lat != 1); d_wr_op = (lat != 0);
        bus.d_address = $urandom; bus.d_wdata = rnd_line();
      end
      if ($urandom_range(0, 3) == 0) bus.i_address = $urandom;
      if ($urandom_range(0, 3) == 0) begin bus.d_address = $urandom; bus.d_wdata = rnd_line(); end
    end
    bus.i_read  = i_pend;
    bus.d_read  = d_pend & d_rd_op;
    bus.d_write = d_pend & d_wr_op;
    if (cyc >= free_cycle) begin
      ir = i_pend; dr = d_pend;
      if (ir && dr) m_c++;
      if (ir || dr) begin
        pick_d = dr && (!ir || !last_grant_d);
        last_grant_d = pick_d; cur_d = pick_d; grant_cycle = cyc;
        lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 6);
        resp_cycle = cyc + lat; free_cycle = resp_cycle + 2;
        if (pick_d) begin
          m_d++; cur_wr = d_wr_op;
          exp_mem_q.push_back('{d_wr_op, bus.d_address, bus.d_wdata});
        end else begin
          m_i++; cur_wr = 1'b0;
          exp_mem_q.push_back('{1'b0, bus.i_address, {LW{1'b0}}});
        end
      end
    end
  endtask

  // Monitor: checks downstream requests and upstream responses as they appear.
  bit            in_txn = 1'b0, held_wr, d_known = 1'b1;
  logic [AW-1:0] held_addr;
  logic [LW-1:0] held_wdata, mon_last_i = '0, mon_last_d = '0;
  always @(negedge clk) begin : monitor
    resp_t re;
    mem_t  me;
    bit    act;
    if (bus.i_resp || bus.d_resp) begin
      if (bus.i_resp && bus.d_resp) chk("both_resp", 1'b1, 1'b0);
      if (exp_resp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_resp: i_resp=%b d_resp=%b, expected no response", bus.i_resp, bus.d_resp);
      end else begin
        re = exp_resp_q.pop_front();
        chk("resp_target_d", bus.d_resp, re.is_d);
        if (re.is_d && !re.wr) begin
          chk("d_rdata", bus.d_rdata, re.rdata); mon_last_d = re.rdata; d_known = 1'b1;
        end else if (re.is_d) begin
          d_known = 1'b0;
        end else begin
          chk("i_rdata", bus.i_rdata, re.rdata); mon_last_i = re.rdata;
        end
      end
    end else if (!rst) begin
      chk("i_rdata_hold", bus.i_rdata, mon_last_i);
      if (d_known) chk("d_rdata_hold", bus.d_rdata, mon_last_d);
    end
    if (rst) begin
      in_txn = 1'b0; mon_last_i = '0; mon_last_d = '0; d_known = 1'b1;
    end else begin
      act = bus.mem_read | bus.mem_write;
      if (bus.mem_read && bus.mem_write) chk("mem_rd_and_wr", 1'b1, 1'b0);
      if (act && !in_txn) begin
        if (exp_mem_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_mem_req: addr=0x%0h, expected no request", bus.mem_address);
        end else begin
          me = exp_mem_q.pop_front();
          chk("mem_write_op", bus.mem_write, me.wr);
          chk("mem_address", bus.mem_address, me.addr);
          if (me.wr) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
        held_wr = bus.mem_write; held_addr = bus.mem_address; held_wdata = bus.mem_wdata;
        in_txn = 1'b1;
      end else if (act) begin
        chk("mem_op_stable", bus.mem_write, held_wr);
        chk("mem_address_stable", bus.mem_address, held_addr);
        chk("mem_wdata_stable", bus.mem_wdata, held_wdata);
      end else if (in_txn) begin
        chk("mem_req_dropped_early", 1'b0, 1'b1);
        in_txn = 1'b0;
      end
      if (act && bus.mem_resp) in_txn = 1'b0;
    end
  end

  // Fixed-priority instance with 2-bit counters: dcache always wins, counters saturate.
  initial begin : fp_proc
    int serve_cnt, n_i, n_d;
    bit ok3;
    serve_cnt = 0; n_i = 0; n_d = 0; ok3 = 1'b0;
    rst_fp = 1'b1;
    bus_fp.i_read = 1'b0; bus_fp.d_read = 1'b0; bus_fp.d_write = 1'b0;
    bus_fp.i_address = 32'h0000_0040; bus_fp.d_address = 32'h0000_0080;
    bus_fp.d_wdata = '0; bus_fp.mem_resp = 1'b0; bus_fp.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_fp = 1'b0; bus_fp.i_read = 1'b1; bus_fp.d_read = 1'b1;
    for (int k = 0; k < 200 && (n_i + n_d) < 5; k++) begin
      @(posedge clk); #1;
      if (bus_fp.mem_read || bus_fp.mem_write) serve_cnt++;
      else serve_cnt = 0;
      bus_fp.mem_resp = (serve_cnt == 2);
      bus_fp.mem_rdata = rnd_line();
      #1;
      if (bus_fp.i_resp) n_i++;
      if (bus_fp.d_resp) n_d++;
      if ((n_i + n_d) == 3 && !ok3) begin
        ok3 = 1'b1;
        chk("fp_d_grant_after_3", fd_cnt, 2'd3);
        chk("fp_i_grant_after_3", fi_cnt, 2'd0);
        chk("fp_conflict_after_3", fc_cnt, 2'd3);
      end
      if ((n_i + n_d) == 5) begin bus_fp.i_read = 1'b0; bus_fp.d_read = 1'b0; end
    end
    if ((n_i + n_d) < 5) chk("fp_timeout_resp_count", n_i + n_d, 5);
    @(posedge clk); #1 bus_fp.mem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fp_d_grant_saturated", fd_cnt, 2'd3);
    chk("fp_conflict_saturated", fc_cnt, 2'd3);
    chk("fp_i_grant_zero", fi_cnt, 2'd0);
    chk("fp_i_resp_count", n_i, 0);
    fp_done = 1'b1;
  end

  initial begin : stim
    int guard;
    rand_en = 1'b0; use_fixed = 1'b0; fixed_lat = 0; fixed_rdata = '0;
    d_rd_op = 1'b0; d_wr_op = 1'b0;
    bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    do_reset();

    // Reset state after 5 idle cycles.
    repeat (5) run_cycle();
    chk("rst_i_resp", bus.i_resp, 1'b0);
    chk("rst_d_resp", bus.d_resp, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_address", bus.mem_address, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    chk("rst_d_rdata", bus.d_rdata, '0);
    chk("rst_i_grant_cnt", i_cnt, 32'd0);
    chk("rst_d_grant_cnt", d_cnt, 32'd0);
    chk("rst_conflict_cnt", c_cnt, 32'd0);

    // Single icache read, memory answers on the 4th serve cycle.
    use_fixed = 1'b1; fixed_rdata = {32{8'hA5}}; fixed_lat = 4;
    i_pend = 1'b1; bus.i_address = 32'h0000_0060;
    repeat (8) run_cycle();
    chk("single_i_grant_cnt", i_cnt, m_i);
    chk("single_d_grant_cnt", d_cnt, m_d);
    chk("single_resp_drained", exp_resp_q.size(), 0);

    // Simultaneous requests after reset: dcache first, then icache.
    do_reset();
    fixed_lat = 3; fixed_rdata = {16{16'h5AC3}};
    i_pend = 1'b1; bus.i_address = 32'h0000_0100;
    d_pend = 1'b1; d_rd_op = 1'b1; d_wr_op = 1'b0; bus.d_address = 32'h0000_0200;
    repeat (16) run_cycle();
    chk("both_conflict_cnt", c_cnt, m_c);
    chk("both_d_grant_cnt", d_cnt, m_d);
    chk("both_i_grant_cnt", i_cnt, m_i);
    chk("both_resp_drained", exp_resp_q.size(), 0);

    // Writeback with the requester's address changing mid-transaction.
    fixed_lat = 5;
    d_pend = 1'b1; d_rd_op = 1'b0; d_wr_op = 1'b1;
    bus.d_address = 32'h0000_1000; bus.d_wdata = {8{32'h1234_5678}};
    repeat (3) run_cycle();
    bus.d_address = 32'h0000_2000; bus.d_wdata = rnd_line();
    repeat (8) run_cycle();
    // Read and write together counts as a write.
    fixed_lat = 2;
    d_pend = 1'b1; d_rd_op = 1'b1; d_wr_op = 1'b1; bus.d_address = 32'h0000_3000;
    repeat (6) run_cycle();
    chk("wb_d_grant_cnt", d_cnt, m_d);
    chk("wb_resp_drained", exp_resp_q.size(), 0);

    // Reset two cycles into an icache transaction with mem_resp arriving.
    do_reset();
    fixed_lat = 20; i_pend = 1'b1; bus.i_address = 32'h0000_0080;
    repeat (3) run_cycle();
    @(posedge clk); #1;
    rst = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = rnd_line();
    i_pend = 1'b0; bus.i_read = 1'b0;
    chk("serve_before_reset_edge", bus.mem_read, 1'b1);
    chk("resp_gated_by_reset", bus.i_resp, 1'b0);
    @(posedge clk); #1;
    chk("mem_read_after_reset", bus.mem_read, 1'b0);
    chk("i_resp_after_reset", bus.i_resp, 1'b0);
    rst = 1'b0; bus.mem_resp = 1'b0;
    model_init();
    repeat (3) run_cycle();
    chk("reset_mid_i_grant_cnt", i_cnt, 32'd0);

    // Randomized traffic against the model, then drain.
    use_fixed = 1'b0; fixed_lat = 0; rand_en = 1'b1;
    repeat (3000) run_cycle();
    rand_en = 1'b0; guard = 0;
    while ((i_pend || d_pend || cyc < free_cycle) && guard < 100) begin
      run_cycle(); guard++;
    end
    if (guard >= 100) chk("drain_timeout", guard, 0);
    repeat (3) run_cycle();
    chk("rand_i_grant_cnt", i_cnt, m_i);
    chk("rand_d_grant_cnt", d_cnt, m_d);
    chk("rand_conflict_cnt", c_cnt, m_c);
    chk("rand_mem_q_drained", exp_mem_q.size(), 0);
    chk("rand_resp_q_drained", exp_resp_q.size(), 0);

    guard = 0;
    while (!fp_done && guard < 1000) begin @(posedge clk); guard++; end
    if (!fp_done) chk("fp_instance_timeout", fp_done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Arbitrates the single shared line-sized port of the L2/physical-memory side between the icache miss port and the dcache miss/writeback port.
- Sits between icache/dcache line interfaces and l2_cache inside mp4.
- Latches one request per grant and holds it stable downstream until response.
- Returns the response only to the granted cache; exposes grant/conflict counters for bench statistics.

Parameters:
- LINE_W, 256, cache line / burst data width in bits
- ADDR_W, 32, line address width
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = dcache fixed priority
- CNT_W, 32, width of statistics counters (saturating)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_read  in  1  icache line read request
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  icache response, 1-cycle pulse
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line writeback request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  dcache response, 1-cycle pulse
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_address  out  ADDR_W  downstream address
- mem_wdata  out  LINE_W  downstream write data
- mem_rdata  in  LINE_W  downstream read data
- mem_resp  in  1  downstream response
- i_grant_cnt  out  CNT_W  icache grants since reset
- d_grant_cnt  out  CNT_W  dcache grants since reset
- conflict_cnt  out  CNT_W  IDLE cycles with both caches requesting

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Reset state: state=IDLE, last_grant=I. Outputs i_resp, d_resp, mem_read, mem_write = 0. mem_address, mem_wdata, i_rdata, d_rdata = 0. All counters = 0.
- States:
  - IDLE: arbitrate; no downstream request.
  - SERVE_I: icache transaction in flight.
  - SERVE_D: dcache transaction in flight.
  - DONE: one cycle, lets the requester drop its request before re-arbitration.
- Request definitions: i_req = i_read; d_req = d_read | d_write.
- IDLE arbitration (on clock edge):
  - Only i_req: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both, ROUND_ROBIN=1: grant the requester opposite last_grant.
  - Both, ROUND_ROBIN=0: grant dcache.
  - Both requesting: conflict_cnt increments.
- Latching at grant:
  - Address, wdata and op latch into registers.
  - Dcache with d_read and d_write both high: treated as write.
  - last_grant updates; the matching grant counter increments.
- SERVE_x:
  - mem_read / mem_write come from latched op; mem_address / mem_wdata come from latched registers.
  - All four are stable from the first SERVE cycle until the cycle mem_resp is seen.
  - Minimum latency: request in IDLE at cycle 0 -> mem_read/mem_write high at cycle 1.
  - Requester dropping its request during SERVE is ignored; the transaction completes.
- Response, in the cycle mem_resp=1 while in SERVE_x:
  - x_resp=1 combinationally; x_rdata = mem_rdata.
  - The other cache's resp stays 0; its rdata holds its last value.
  - Next state = DONE. mem_read/mem_write deassert from DONE onward.
  - For writes, d_resp pulses the same way; d_rdata is don't-care.
- DONE: no requests or resps driven; next state = IDLE. Back-to-back grants are therefore spaced by at least one IDLE cycle after DONE.
- mem_resp outside SERVE states: ignored, no resp forwarded.
- Counters: saturate at all-ones, no wrap.
- Reset mid-transaction: next edge forces IDLE and deasserts mem_read/mem_write. The pending response is dropped and never forwarded.

Test Plan:
- Reset, idle 5 cycles -> all outputs 0, counters 0, no mem_read/mem_write.
- i_read=1, i_address=0x0000_0060; mem_resp after 4 cycles with rdata=0xA5..A5 -> mem_read high cycles 1–4, mem_address=0x60; i_resp single pulse with i_rdata=0xA5..A5; d_resp=0; i_grant_cnt=1.
- Both requesting, ROUND_ROBIN=1, reset last_grant=I -> dcache served first, icache second; conflict_cnt=1; d_grant_cnt=1, i_grant_cnt=1 after both complete.
- d_write=1, d_address=0x1000, d_wdata=0x1234…; d_address changed to 0x2000 mid-transaction -> mem_address stays 0x1000 and mem_wdata is unchanged until mem_resp; d_resp pulses once.
- ROUND_ROBIN=0, both caches requesting continuously for 3 transactions -> dcache granted every time; i_grant_cnt=0.
- rst asserted 2 cycles into SERVE_I, then mem_resp=1 -> mem_read=0 on the next edge; i_resp never asserted; state IDLE.
